// File: rtl/phy_tx_lanes_if.sv
// Upstream word handshake into the lane transmitter: word, valid and FIFO-ready.
interface phy_tx_lanes_if;
  logic [31:0] data_in;
  logic        valid_in;
  logic        ready_out;

  modport master (output data_in, output valid_in, input ready_out);
  modport slave  (input data_in, input valid_in, output ready_out);
endinterface

// File: rtl/phy_tx_lanes.sv
// Single-clock PHY transmit path: word FIFO, byte striping across LANES lanes,
// MSB-first serialisation per lane with IDLE_SYM fill when nothing is queued.
module phy_tx_lanes #(
  parameter int          LANES    = 2,
  parameter int          DEPTH    = 4,
  parameter logic [7:0]  IDLE_SYM = 8'hBC
) (
  input  logic                     clk_32f,
  input  logic                     reset,
  phy_tx_lanes_if.slave            tx,
  output logic [LANES-1:0]         data_out,
  output logic                     active_out,
  output logic                     overflow_err,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int W  = 32 / LANES;
  localparam int NB = 4 / LANES;
  localparam int CW = $clog2(W);
  localparam int AW = $clog2(DEPTH);

  generate
    if (!(LANES == 1 || LANES == 2 || LANES == 4)) begin : g_bad_lanes
      $error("phy_tx_lanes: LANES must be 1, 2 or 4");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("phy_tx_lanes: DEPTH must be a power of 2 and at least 2");
    end
  endgenerate

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] slot_cnt;
  logic [W-1:0]  sreg [LANES];
  logic          last;
  logic          have_word;
  logic          push;
  logic          pop;

  // Byte k lands on lane k mod LANES; earlier bytes occupy the more significant bits.
  function automatic logic [W-1:0] stripe(input logic [31:0] w, input int l);
    logic [W-1:0] v;
    int           k;
    v = '0;
    for (int j = 0; j < NB; j++) begin
      k = l + j * LANES;
      v[W-1-8*j -: 8] = w[31-8*k -: 8];
    end
    return v;
  endfunction

  assign last         = (slot_cnt == CW'(W - 1));
  assign have_word    = (fifo_level != '0);
  assign tx.ready_out = (fifo_level < (AW + 1)'(DEPTH));
  assign push         = tx.valid_in && tx.ready_out;
  assign pop          = last && have_word;

  always_comb begin
    data_out = '0;
    for (int l = 0; l < LANES; l++) data_out[l] = sreg[l][W-1];
  end

  always_ff @(posedge clk_32f) begin
    if (push) mem[wr_ptr] <= tx.data_in;
  end

  always_ff @(posedge clk_32f) begin
    if (reset) begin
      slot_cnt     <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_level   <= '0;
      active_out   <= 1'b0;
      overflow_err <= 1'b0;
      for (int l = 0; l < LANES; l++) sreg[l] <= {NB{IDLE_SYM}};
    end else begin
      slot_cnt <= last ? '0 : slot_cnt + 1'b1;

      // All lanes reload together at the slot boundary so words stay lane-aligned.
      if (last) begin
        active_out <= have_word;
        for (int l = 0; l < LANES; l++)
          sreg[l] <= have_word ? stripe(mem[rd_ptr], l) : {NB{IDLE_SYM}};
      end else begin
        for (int l = 0; l < LANES; l++) sreg[l] <= {sreg[l][W-2:0], 1'b0};
      end

      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;

      if (push && !pop)      fifo_level <= fifo_level + 1'b1;
      else if (pop && !push) fifo_level <= fifo_level - 1'b1;

      if (tx.valid_in && !tx.ready_out) overflow_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_phy_tx_lanes.sv
// Bench for phy_tx_lanes: LANES=1/2/4 instances driven with the same stream,
// directed slot checks plus a randomized run against a queue-based reference model.
`timescale 1ns/1ps
module tb_phy_tx_lanes;
  localparam int         DEPTH = 4;
  localparam logic [7:0] IDLE  = 8'hBC;

  logic        clk_32f = 1'b0;
  logic        reset   = 1'b1;
  logic        valid   = 1'b0;
  logic [31:0] data    = '0;

  int errors = 0;
  int checks = 0;

  initial forever #5 clk_32f = ~clk_32f;

  phy_tx_lanes_if if1 ();
  phy_tx_lanes_if if2 ();
  phy_tx_lanes_if if4 ();
  assign if1.data_in = data;  assign if1.valid_in = valid;
  assign if2.data_in = data;  assign if2.valid_in = valid;
  assign if4.data_in = data;  assign if4.valid_in = valid;

  logic [0:0] d1;  logic [1:0] d2;  logic [3:0] d4;
  logic a1, a2, a4, o1, o2, o4;
  logic [2:0] lv1, lv2, lv4;

  phy_tx_lanes #(.LANES(1), .DEPTH(DEPTH), .IDLE_SYM(IDLE)) u1 (
    .clk_32f(clk_32f), .reset(reset), .tx(if1.slave), .data_out(d1),
    .active_out(a1), .overflow_err(o1), .fifo_level(lv1));
  phy_tx_lanes #(.LANES(2), .DEPTH(DEPTH), .IDLE_SYM(IDLE)) u2 (
    .clk_32f(clk_32f), .reset(reset), .tx(if2.slave), .data_out(d2),
    .active_out(a2), .overflow_err(o2), .fifo_level(lv2));
  phy_tx_lanes #(.LANES(4), .DEPTH(DEPTH), .IDLE_SYM(IDLE)) u4 (
    .clk_32f(clk_32f), .reset(reset), .tx(if4.slave), .data_out(d4),
    .active_out(a4), .overflow_err(o4), .fifo_level(lv4));

  // index 0: LANES=1, 1: LANES=2, 2: LANES=4
  int         lanes_of [3] = '{1, 2, 4};
  logic [3:0] obs_d [3];
  logic       obs_a [3], obs_o [3], obs_r [3];
  logic [2:0] obs_l [3];
  assign obs_d[0] = {3'b000, d1}; assign obs_d[1] = {2'b00, d2}; assign obs_d[2] = d4;
  assign obs_a[0] = a1;  assign obs_a[1] = a2;  assign obs_a[2] = a4;
  assign obs_o[0] = o1;  assign obs_o[1] = o2;  assign obs_o[2] = o4;
  assign obs_r[0] = if1.ready_out; assign obs_r[1] = if2.ready_out; assign obs_r[2] = if4.ready_out;
  assign obs_l[0] = lv1; assign obs_l[1] = lv2; assign obs_l[2] = lv4;

  // Reference model: a word queue, the word currently on the wire, and the
  // bit position within the slot (cycles since reset modulo the slot length).
  logic [31:0] mq [3][$];
  logic [31:0] m_cur [3];
  logic        m_act [3], m_ovf [3];
  int          m_pos [3];

  function automatic logic [31:0] lane_vec(input logic [31:0] w, input int lanes, input int l);
    logic [31:0] v;
    v = '0;
    for (int k = 0; k < 4; k++)
      if (k % lanes == l) v = (v << 8) | 32'(w[31-8*k -: 8]);
    return v;
  endfunction

  initial forever begin
    @(posedge clk_32f);
    for (int i = 0; i < 3; i++) begin
      int w, sz;
      w  = 32 / lanes_of[i];
      sz = mq[i].size();
      if (reset) begin
        mq[i].delete();
        m_pos[i] = 0; m_cur[i] = {4{IDLE}}; m_act[i] = 1'b0; m_ovf[i] = 1'b0;
      end else begin
        if (m_pos[i] == w - 1) begin
          if (sz > 0) begin m_cur[i] = mq[i].pop_front(); m_act[i] = 1'b1; end
          else begin m_cur[i] = {4{IDLE}}; m_act[i] = 1'b0; end
        end
        if (valid) begin
          if (sz < DEPTH) mq[i].push_back(data);
          else m_ovf[i] = 1'b1;
        end
        m_pos[i] = (m_pos[i] + 1) % w;
      end
    end
  end

  // Capture buffers for directed tests; index 0 is the first cycle after reset drops.
  logic [3:0]  cap_d [3][0:199];
  logic        cap_a [3][0:199];
  logic        cap_r [3][0:199];
  logic        cap_o [3][0:199];
  logic [2:0]  cap_l [3][0:199];
  logic [31:0] pw [8];

  task automatic do_reset;
    @(negedge clk_32f);
    reset = 1'b1; valid = 1'b0;
    repeat (3) @(negedge clk_32f);
    reset = 1'b0;
  endtask

  task automatic capture(input int n, input int push_at, input int npush);
    for (int c = 0; c < n; c++) begin
      if (c > 0) @(negedge clk_32f);
      for (int i = 0; i < 3; i++) begin
        cap_d[i][c] = obs_d[i]; cap_a[i][c] = obs_a[i]; cap_r[i][c] = obs_r[i];
        cap_o[i][c] = obs_o[i]; cap_l[i][c] = obs_l[i];
      end
      valid = (c >= push_at) && (c < push_at + npush);
      data  = valid ? pw[c - push_at] : 32'h0;
    end
  endtask

  function automatic logic [31:0] ext(input int i, input int l, input int s, input int len);
    logic [31:0] v;
    v = '0;
    for (int c = s; c < s + len; c++) v = {v[30:0], cap_d[i][c][l]};
    return v;
  endfunction

  function automatic int count_act(input int i, input int s, input int len, input logic val);
    int n;
    n = 0;
    for (int c = s; c < s + len; c++) if (cap_a[i][c] !== val) n++;
    return n;
  endfunction

  task automatic test_reset;
    logic [3:0] ones;
    @(negedge clk_32f);
    reset = 1'b1; valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_32f);
      for (int i = 0; i < 3; i++) begin
        ones = 4'((1 << lanes_of[i]) - 1);
        ones = IDLE[7] ? ones : 4'h0;
        checks++;
        if (obs_d[i] !== ones) begin
          errors++; $display("FAIL reset_data inst%0d got %b want %b", i, obs_d[i], ones);
        end
      end
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({obs_r[i], obs_l[i], obs_a[i], obs_o[i]} !== {1'b1, 3'd0, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL reset_status inst%0d got r=%b l=%0d a=%b o=%b want r=1 l=0 a=0 o=0",
                 i, obs_r[i], obs_l[i], obs_a[i], obs_o[i]);
      end
    end
    capture(40, 0, 0);
    for (int l = 0; l < 2; l++)
      for (int s = 0; s < 32; s += 16) begin
        checks++;
        if (ext(1, l, s, 16) !== 32'h0000BCBC) begin
          errors++; $display("FAIL idle_l2 lane%0d at %0d got %h want bcbc", l, s, ext(1, l, s, 16));
        end
      end
    for (int l = 0; l < 4; l++) begin
      checks++;
      if (ext(2, l, 0, 8) !== 32'hBC) begin
        errors++; $display("FAIL idle_l4 lane%0d got %h want bc", l, ext(2, l, 0, 8));
      end
    end
    checks++;
    if (ext(0, 0, 0, 32) !== 32'hBCBCBCBC) begin
      errors++; $display("FAIL idle_l1 got %h want bcbcbcbc", ext(0, 0, 0, 32));
    end
    checks++;
    if (count_act(1, 0, 40, 1'b0) != 0) begin
      errors++; $display("FAIL idle_active got %0d high cycles want 0", count_act(1, 0, 40, 1'b0));
    end
  endtask

  task automatic test_single;
    logic [31:0] want4 [4];
    want4 = '{32'hDE, 32'hAD, 32'hBE, 32'hEF};
    do_reset();
    pw[0] = 32'hDEADBEEF;
    capture(80, 0, 1);
    checks++;
    if (ext(1, 0, 16, 16) !== 32'hDEBE) begin
      errors++; $display("FAIL single_l2_lane0 got %h want debe", ext(1, 0, 16, 16));
    end
    checks++;
    if (ext(1, 1, 16, 16) !== 32'hADEF) begin
      errors++; $display("FAIL single_l2_lane1 got %h want adef", ext(1, 1, 16, 16));
    end
    checks++;
    if (count_act(1, 0, 16, 1'b0) + count_act(1, 16, 16, 1'b1) + count_act(1, 32, 48, 1'b0) != 0) begin
      errors++; $display("FAIL single_active got %0d wrong cycles want 0",
                         count_act(1, 0, 16, 1'b0) + count_act(1, 16, 16, 1'b1) + count_act(1, 32, 48, 1'b0));
    end
    checks++;
    if (ext(1, 0, 32, 16) !== 32'hBCBC) begin
      errors++; $display("FAIL single_idle_after got %h want bcbc", ext(1, 0, 32, 16));
    end
    for (int l = 0; l < 4; l++) begin
      checks++;
      if (ext(2, l, 8, 8) !== want4[l]) begin
        errors++; $display("FAIL single_l4 lane%0d got %h want %h", l, ext(2, l, 8, 8), want4[l]);
      end
    end
  endtask

  task automatic test_lane_counts;
    logic [31:0] want4 [4];
    want4 = '{32'h12, 32'h34, 32'h56, 32'h78};
    do_reset();
    pw[0] = 32'h12345678;
    capture(24, 0, 1);
    for (int l = 0; l < 4; l++) begin
      checks++;
      if (ext(2, l, 8, 8) !== want4[l]) begin
        errors++; $display("FAIL lanes4 lane%0d got %h want %h", l, ext(2, l, 8, 8), want4[l]);
      end
    end
    checks++;
    if (count_act(2, 8, 8, 1'b1) + count_act(2, 16, 8, 1'b0) != 0) begin
      errors++; $display("FAIL lanes4_active got %0d wrong want 0", count_act(2, 8, 8, 1'b1) + count_act(2, 16, 8, 1'b0));
    end
    do_reset();
    pw[0] = 32'hA5A50F0F;
    capture(100, 0, 1);
    checks++;
    if (ext(0, 0, 32, 32) !== 32'hA5A50F0F) begin
      errors++; $display("FAIL lanes1 got %h want a5a50f0f", ext(0, 0, 32, 32));
    end
    checks++;
    if (count_act(0, 32, 32, 1'b1) + count_act(0, 64, 32, 1'b0) != 0) begin
      errors++; $display("FAIL lanes1_active got %0d wrong want 0", count_act(0, 32, 32, 1'b1) + count_act(0, 64, 32, 1'b0));
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] v;
    do_reset();
    for (int j = 0; j < 6; j++) pw[j] = $urandom;
    capture(100, 0, 6);
    checks++;
    if ({cap_r[1][3], cap_l[1][3], cap_r[1][4], cap_l[1][4]} !== {1'b1, 3'd3, 1'b0, 3'd4}) begin
      errors++; $display("FAIL bp_ready got r3=%b l3=%0d r4=%b l4=%0d want 1 3 0 4",
                         cap_r[1][3], cap_l[1][3], cap_r[1][4], cap_l[1][4]);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({cap_o[i][4], cap_o[i][5], cap_o[i][90]} !== 3'b011) begin
        errors++; $display("FAIL bp_overflow inst%0d got %b want 011", i, {cap_o[i][4], cap_o[i][5], cap_o[i][90]});
      end
    end
    checks++;
    if (cap_l[1][16] !== 3'd3) begin
      errors++; $display("FAIL bp_level_after_pop got %0d want 3", cap_l[1][16]);
    end
    for (int j = 0; j < 4; j++)
      for (int l = 0; l < 2; l++) begin
        v = lane_vec(pw[j], 2, l);
        checks++;
        if (ext(1, l, 16 + 16 * j, 16) !== v) begin
          errors++; $display("FAIL bp_word%0d lane%0d got %h want %h", j, l, ext(1, l, 16 + 16 * j, 16), v);
        end
      end
    checks++;
    if (count_act(1, 16, 64, 1'b1) + count_act(1, 80, 20, 1'b0) != 0) begin
      errors++; $display("FAIL bp_gapfree got %0d wrong want 0", count_act(1, 16, 64, 1'b1) + count_act(1, 80, 20, 1'b0));
    end
  endtask

  task automatic test_load_edge_and_reset;
    logic [31:0] v;
    logic [3:0]  ones;
    do_reset();
    pw[0] = $urandom;
    capture(50, 15, 1);
    checks++;
    if (count_act(1, 16, 16, 1'b0) + count_act(1, 32, 16, 1'b1) != 0) begin
      errors++; $display("FAIL loadedge_active got %0d wrong want 0", count_act(1, 16, 16, 1'b0) + count_act(1, 32, 16, 1'b1));
    end
    for (int l = 0; l < 2; l++) begin
      v = lane_vec(pw[0], 2, l);
      checks++;
      if ({ext(1, l, 16, 16), ext(1, l, 32, 16)} !== {32'hBCBC, v}) begin
        errors++; $display("FAIL loadedge_l2 lane%0d got %h/%h want bcbc/%h", l, ext(1, l, 16, 16), ext(1, l, 32, 16), v);
      end
    end
    v = lane_vec(pw[0], 4, 0);
    checks++;
    if ({ext(2, 0, 16, 8), ext(2, 0, 24, 8)} !== {32'hBC, v}) begin
      errors++; $display("FAIL loadedge_l4 got %h/%h want bc/%h", ext(2, 0, 16, 8), ext(2, 0, 24, 8), v);
    end

    do_reset();
    pw[0] = 32'hDEADBEEF;
    capture(24, 0, 1);
    reset = 1'b1; valid = 1'b1; data = 32'h13579BDF;
    @(negedge clk_32f);
    for (int i = 0; i < 3; i++) begin
      ones = IDLE[7] ? 4'((1 << lanes_of[i]) - 1) : 4'h0;
      checks++;
      if ({obs_d[i], obs_l[i], obs_a[i], obs_r[i]} !== {ones, 3'd0, 1'b0, 1'b1}) begin
        errors++; $display("FAIL midreset inst%0d got d=%b l=%0d a=%b r=%b want d=%b l=0 a=0 r=1",
                           i, obs_d[i], obs_l[i], obs_a[i], obs_r[i], ones);
      end
    end
    reset = 1'b0; valid = 1'b0;
    capture(40, 0, 0);
    checks++;
    if (count_act(1, 0, 40, 1'b0) != 0 || cap_l[1][1] !== 3'd0 || ext(1, 0, 16, 16) !== 32'hBCBC) begin
      errors++; $display("FAIL midreset_after got act_err=%0d l=%0d lane0=%h want 0 0 bcbc",
                         count_act(1, 0, 40, 1'b0), cap_l[1][1], ext(1, 0, 16, 16));
    end
  endtask

  task automatic test_random;
    int thr;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk_32f);
      for (int i = 0; i < 3; i++) begin
        logic [3:0]  ed;
        logic [31:0] v;
        int          w;
        w  = 32 / lanes_of[i];
        ed = '0;
        for (int l = 0; l < lanes_of[i]; l++) begin
          v = lane_vec(m_cur[i], lanes_of[i], l);
          ed[l] = v[w - 1 - m_pos[i]];
        end
        checks++;
        if (obs_d[i] !== ed) begin
          errors++;
          if (errors < 40) $display("FAIL rand_data inst%0d cyc%0d got %b want %b", i, c, obs_d[i], ed);
        end
        checks++;
        if ({obs_a[i], obs_o[i], obs_r[i], obs_l[i]} !==
            {m_act[i], m_ovf[i], (mq[i].size() < DEPTH), 3'(mq[i].size())}) begin
          errors++;
          if (errors < 40)
            $display("FAIL rand_status inst%0d cyc%0d got a=%b o=%b r=%b l=%0d want a=%b o=%b l=%0d",
                     i, c, obs_a[i], obs_o[i], obs_r[i], obs_l[i], m_act[i], m_ovf[i], mq[i].size());
        end
      end
      thr   = (c < 1000) ? 5 : (c < 2000) ? 20 : 90;
      valid = ($urandom_range(0, 99) < thr);
      data  = $urandom;
    end
    valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_lane_counts();
    test_back_to_back();
    test_load_edge_and_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
